// File: rtl/cafe_pkg.sv
// Shared types and constants for the coffee-machine change-payout path.
package cafe_pkg;

  localparam int AMT_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } vuelto_state_t;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_HI_SEL = 2'd1,
    COIN_LO_SEL = 2'd2
  } coin_t;

endpackage

// File: rtl/dispensador_vuelto_contador_pulso.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module contador_pulso #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dispensador_vuelto.sv
// Change payout: captures the amount on an enable_fin rising edge and ejects
// coins greedily (high, then low denomination) through the hopper.
module dispensador_vuelto
  import cafe_pkg::*;
#(
  parameter int WIDTH     = AMT_WIDTH,
  parameter int COIN_HI   = 500,
  parameter int COIN_LO   = 100,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk_fpga,
  input  logic             rst,
  input  logic             enable_fin,
  input  logic [WIDTH-1:0] devuelto,
  input  logic             hopper_ready,
  output logic             out_hi,
  output logic             out_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] restante,
  output logic             residuo_err,
  output vuelto_state_t    o_dbg_state
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Handshake: an eject pulse begins only on a cycle where SELECT has a coin
  // and hopper_ready=1; once the pulse starts, hopper_ready is not looked at.
  vuelto_state_t    r_state;
  logic             r_en_q;
  logic             r_out_hi;
  logic             r_out_lo;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_restante;
  logic             r_err;

  logic             w_start;
  coin_t            w_coin;
  logic [WIDTH-1:0] w_coin_val;
  logic             w_fire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_zero;

  assign w_start = enable_fin & ~r_en_q;

  always_comb begin
    w_coin     = COIN_NONE;
    w_coin_val = '0;
    if (r_restante >= WIDTH'(COIN_HI)) begin
      w_coin     = COIN_HI_SEL;
      w_coin_val = WIDTH'(COIN_HI);
    end else if (r_restante >= WIDTH'(COIN_LO)) begin
      w_coin     = COIN_LO_SEL;
      w_coin_val = WIDTH'(COIN_LO);
    end
  end

  assign w_fire     = (r_state == ST_SELECT) && (w_coin != COIN_NONE) && hopper_ready;
  assign w_load     = w_fire || ((r_state == ST_PULSE) && w_cnt_zero);
  assign w_load_val = w_fire ? CNT_W'(PULSE_CYC - 1) : CNT_W'(GAP_CYC - 1);

  // Single timer shared by the pulse-high and inter-coin gap intervals.
  contador_pulso #(.CW(CNT_W)) u_timer (
    .i_clk   (clk_fpga),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk_fpga or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_en_q     <= 1'b0;
      r_out_hi   <= 1'b0;
      r_out_lo   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_restante <= '0;
      r_err      <= 1'b0;
    end else begin
      r_en_q <= enable_fin;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_restante <= devuelto;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_state    <= (devuelto == '0) ? ST_FINISH : ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_coin == COIN_NONE) begin
            r_err   <= (r_restante != '0);
            r_state <= ST_FINISH;
          end else if (hopper_ready) begin
            r_out_hi   <= (w_coin == COIN_HI_SEL);
            r_out_lo   <= (w_coin == COIN_LO_SEL);
            r_restante <= r_restante - w_coin_val;
            r_state    <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (w_cnt_zero) begin
            r_out_hi <= 1'b0;
            r_out_lo <= 1'b0;
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_cnt_zero) r_state <= ST_SELECT;
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_hi      = r_out_hi;
  assign out_lo      = r_out_lo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign restante    = r_restante;
  assign residuo_err = r_err;
  assign o_dbg_state = r_state;

endmodule
